// File: rtl/cmp_seq_pkg.sv
// Shared definitions for the comparator sequencer: the FSM state set,
// default timing parameters, statistics counter width and a one-hot helper.
package cmp_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_WAIT = 3'd3,
    ST_OP   = 3'd4,
    ST_CAPT = 3'd5,
    ST_HOLD = 3'd6
  } state_t;

  localparam int WAIT_CYC_DEF = 34;
  localparam int OP_CYC_DEF   = 2;
  localparam int CNT_W        = 16;

  // True when exactly one of the three comparator result bits is set.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/cmp_seq_timer.sv
// Loadable down-counter used to time the WAIT and OP phases.
// Loading N-1 makes o_done rise after exactly N cycles in the phase.
module cmp_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         res,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/cmp_sequencer.sv
// Comparator sequencer: accepts an operand pair, drives clear/load/evaluate
// strobes to an external comparator, captures its L/E/G result and holds it
// for downstream with a valid/ready handshake.
// Optional macro CMP_SEQ_STATS_EN adds saturating per-result counters.
module cmp_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int WAIT_CYC = WAIT_CYC_DEF,  // must be >= 1
  parameter int OP_CYC   = OP_CYC_DEF     // must be >= 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  output logic              cmp_res,
  output logic              cmp_load,
  output logic [31:0]       cmp_a,
  output logic [31:0]       cmp_b,
  output logic              cmp_op,
  input  logic              cmp_L,
  input  logic              cmp_E,
  input  logic              cmp_G,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_lt,
  output logic              out_eq,
  output logic              out_gt,
  output logic              out_err
`ifdef CMP_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]  cnt_lt,
  output logic [CNT_W-1:0]  cnt_eq,
  output logic [CNT_W-1:0]  cnt_gt
`endif
);

  localparam int TMR_MAX = (WAIT_CYC > OP_CYC) ? WAIT_CYC : OP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] WAIT_LD = TMR_W'(WAIT_CYC - 1);
  localparam logic [TMR_W-1:0] OP_LD   = TMR_W'(OP_CYC - 1);

  state_t      r_state;
  logic        r_in_ready;
  logic        r_cmp_res;
  logic        r_cmp_load;
  logic        r_cmp_op;
  logic [31:0] r_cmp_a;
  logic [31:0] r_cmp_b;
  logic        r_out_valid;
  logic [2:0]  r_out_bits;
  logic        r_out_err;

  logic             w_tmr_load;
  logic [TMR_W-1:0] w_tmr_value;
  logic             w_tmr_done;
  logic [2:0]       w_sample;

  assign w_sample = {cmp_L, cmp_E, cmp_G};

  // Timer is armed on the last LOAD cycle for WAIT, and on the last WAIT
  // cycle for OP, so each phase sees a freshly loaded count on entry.
  assign w_tmr_load  = (r_state == ST_LOAD) || ((r_state == ST_WAIT) && w_tmr_done);
  assign w_tmr_value = (r_state == ST_LOAD) ? WAIT_LD : OP_LD;

  cmp_seq_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .res     (res),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_done  (w_tmr_done)
  );

  // Sequencing FSM; every output is registered and set on the edge that
  // enters the state in which it must be visible.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_cmp_res   <= 1'b0;
      r_cmp_load  <= 1'b0;
      r_cmp_op    <= 1'b0;
      r_cmp_a     <= '0;
      r_cmp_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_bits  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_cmp_res  <= 1'b0;
      r_cmp_load <= 1'b0;
      r_cmp_op   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_cmp_a    <= in_a;
            r_cmp_b    <= in_b;
            r_in_ready <= 1'b0;
            r_cmp_res  <= 1'b1;
            r_state    <= ST_CLR;
          end
        end
        ST_CLR: begin
          r_cmp_load <= 1'b1;
          r_state    <= ST_LOAD;
        end
        ST_LOAD: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_tmr_done) begin
            r_cmp_op <= 1'b1;
            r_state  <= ST_OP;
          end
        end
        ST_OP: begin
          if (w_tmr_done) begin
            r_state <= ST_CAPT;
          end else begin
            r_cmp_op <= 1'b1;
          end
        end
        ST_CAPT: begin
          r_out_bits  <= w_sample;
          r_out_err   <= ~is_onehot3(w_sample);
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cmp_res   = r_cmp_res;
  assign cmp_load  = r_cmp_load;
  assign cmp_op    = r_cmp_op;
  assign cmp_a     = r_cmp_a;
  assign cmp_b     = r_cmp_b;
  assign out_valid = r_out_valid;
  assign out_lt    = r_out_bits[2];
  assign out_eq    = r_out_bits[1];
  assign out_gt    = r_out_bits[0];
  assign out_err   = r_out_err;

`ifdef CMP_SEQ_STATS_EN
  logic w_capt_ok;
  assign w_capt_ok = (r_state == ST_CAPT) && is_onehot3(w_sample);

  // One saturating counter per result kind: gi=0 less, 1 equal, 2 greater.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;
    // Count only clean (one-hot) captures; hold at all-ones.
    always_ff @(posedge clk or negedge res) begin
      if (!res) begin
        r_cnt <= '0;
      end else if (w_capt_ok && w_sample[2-gi] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign cnt_lt = g_cnt[0].r_cnt;
  assign cnt_eq = g_cnt[1].r_cnt;
  assign cnt_gt = g_cnt[2].r_cnt;
`endif

endmodule
